// File: rtl/fwd_hazard_unit_if.sv
// Decode-side bundle for fwd_hazard_unit: ID instruction fields, pipeline
// control in, hazard/forwarding selects and statistics out.
interface fwd_hazard_unit_if #(
    parameter int REG_AW  = 3,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
);
    logic                      id_valid;
    logic [NUM_SRC*REG_AW-1:0] id_src;
    logic [NUM_SRC-1:0]        id_src_use;
    logic [REG_AW-1:0]         id_dst;
    logic                      id_wb;
    logic                      id_load;
    logic                      id_sp_rd;
    logic                      id_sp_wr;
    logic                      pipe_hold;
    logic                      flush;
    logic                      hazard_stall;
    logic [NUM_SRC*2-1:0]      fwd_sel;
    logic [1:0]                sp_sel;
    logic [CNT_W-1:0]          stall_cnt;
    logic [CNT_W-1:0]          fwd_cnt;

    modport master (
        output id_valid, id_src, id_src_use, id_dst, id_wb, id_load,
               id_sp_rd, id_sp_wr, pipe_hold, flush,
        input  hazard_stall, fwd_sel, sp_sel, stall_cnt, fwd_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_use, id_dst, id_wb, id_load,
               id_sp_rd, id_sp_wr, pipe_hold, flush,
        output hazard_stall, fwd_sel, sp_sel, stall_cnt, fwd_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Decode-stage forwarding selector and load-use hazard detector with shadow
// EX/MEM destination tags. Define FWD_STATS_EN to build the stall/forward counters.
module fwd_hazard_unit #(
    parameter int REG_AW  = 3,
    parameter int NUM_SRC = 2,
    parameter int CNT_W   = 16
) (
    input logic               clk,
    input logic               rst,
    fwd_hazard_unit_if.slave  bus
);
    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] dst;
        logic              wb;
        logic              load;
        logic              sp_wr;
    } entry_t;

    entry_t               ex_e;
    entry_t               mem_e;
    logic [NUM_SRC*2-1:0] fwd_q;
    logic [NUM_SRC*2-1:0] fwd_next;
    logic [1:0]           sp_q;
    logic [1:0]           sp_next;
    logic                 load_match;
    logic                 hazard;
    logic                 any_fwd;

    // A load in EX blocks only the 01 path; the operand may still pick up an
    // older producer in MEM, although the resulting stall discards it anyway.
    always_comb begin
        load_match = 1'b0;
        fwd_next   = '0;
        sp_next    = 2'b00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (bus.id_src_use[i] && ex_e.v && ex_e.wb &&
                ex_e.dst == bus.id_src[i*REG_AW +: REG_AW]) begin
                if (ex_e.load)
                    load_match = 1'b1;
                else
                    fwd_next[2*i +: 2] = 2'b01;
            end
            if (fwd_next[2*i +: 2] == 2'b00 && bus.id_src_use[i] && mem_e.v &&
                mem_e.wb && mem_e.dst == bus.id_src[i*REG_AW +: REG_AW])
                fwd_next[2*i +: 2] = 2'b10;
        end
        // SP updates by loads (post-increment) are ready at EX/MEM, so no load gating.
        if (bus.id_sp_rd && ex_e.v && ex_e.sp_wr)
            sp_next = 2'b01;
        else if (bus.id_sp_rd && mem_e.v && mem_e.sp_wr)
            sp_next = 2'b10;
        if (!bus.id_valid) begin
            fwd_next = '0;
            sp_next  = 2'b00;
        end
        hazard  = bus.id_valid && load_match && !bus.flush;
        any_fwd = (|fwd_next) || (|sp_next);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_e  <= '0;
            mem_e <= '0;
            fwd_q <= '0;
            sp_q  <= 2'b00;
        end else if (!bus.pipe_hold) begin
            mem_e <= ex_e;
            if (bus.flush || hazard) begin
                ex_e  <= '0;
                fwd_q <= '0;
                sp_q  <= 2'b00;
            end else begin
                ex_e  <= '{v: bus.id_valid, dst: bus.id_dst, wb: bus.id_wb,
                          load: bus.id_load, sp_wr: bus.id_sp_wr};
                fwd_q <= fwd_next;
                sp_q  <= sp_next;
            end
        end
    end

    assign bus.hazard_stall = hazard;
    assign bus.fwd_sel      = fwd_q;
    assign bus.sp_sel       = sp_q;

`ifdef FWD_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] fcnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= '0;
            fcnt_q  <= '0;
        end else if (!bus.pipe_hold) begin
            if (hazard && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (!bus.flush && !hazard && any_fwd && fcnt_q != '1)
                fcnt_q <= fcnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_q;
    assign bus.fwd_cnt   = fcnt_q;
`else
    logic unused_any_fwd;
    assign unused_any_fwd = any_fwd;
    assign bus.stall_cnt  = '0;
    assign bus.fwd_cnt    = '0;
`endif
endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
Parameterised successor to the EX-stage forwarding selector. It runs in Decode and keeps its own shadow copy of the destination tags for the instructions in EX and MEM. From these it produces registered per-operand forwarding selects and stack-pointer forwarding selects for the EX stage, and detects load-use hazards. It also generates the decode stall and the EX bubble, and honours the global pipeline hold and flush.

Parameters:
REG_AW, 3, register address width (2**REG_AW architectural registers)
NUM_SRC, 2, number of register operands checked per instruction (operand 0 = src, operand 1 = current dest used as operand)
CNT_W, 16, width of statistics counters (used only with FWD_STATS_EN)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  Decode holds a real instruction
id_src  in  NUM_SRC*REG_AW  flattened operand addresses; operand i at bits [i*REG_AW +: REG_AW]
id_src_use  in  NUM_SRC  operand i is actually read
id_dst  in  REG_AW  destination register of decoded instruction
id_wb  in  1  decoded instruction writes the register file
id_load  in  1  decoded instruction is a memory load (result ready at end of MEM)
id_sp_rd  in  1  decoded instruction reads SP
id_sp_wr  in  1  decoded instruction writes SP
pipe_hold  in  1  global freeze (e.g. memory busy); all state holds
flush  in  1  branch/exception flush of ID and EX
hazard_stall  out  1  combinational; freeze PC and IF/ID, insert bubble into EX
fwd_sel  out  NUM_SRC*2  registered per-operand select for EX
sp_sel  out  2  registered SP operand select for EX
stall_cnt  out  CNT_W  load-use stall cycles counted
fwd_cnt  out  CNT_W  instructions with at least one forwarded operand

Behaviour:
- Select encoding, for fwd_sel and sp_sel:
  - 2'b00 = register file / SP register
  - 2'b01 = EX/MEM result (instruction one ahead)
  - 2'b10 = MEM/WB result (instruction two ahead)
  - 2'b11 is never driven
- Shadow entries ex_e and mem_e each hold {v, dst, wb, load, sp_wr}. They describe the instructions currently in EX and MEM.
- Instructions three or more ahead are not tracked. The register file writes in the first half-cycle, so reads in Decode return the new value.
- Hazard (combinational): hazard_stall = id_valid & ex_e.v & ex_e.load & ex_e.wb & (any i: id_src_use[i] & id_src[i]==ex_e.dst) & !flush.
- Per-operand select (computed from ID inputs and the current shadow entries, registered on advance):
  - if id_src_use[i] & ex_e.v & ex_e.wb & !ex_e.load & ex_e.dst==id_src[i] -> 01;
  - else if id_src_use[i] & mem_e.v & mem_e.wb & mem_e.dst==id_src[i] -> 10;
  - else -> 00.
  - The nearest producer always wins; a load in mem_e forwards as 10.
- SP select: same priority rule using id_sp_rd and the sp_wr bits; no dst compare. A load that writes SP causes no stall.
- Per-cycle update, in priority order:
  1. rst: ex_e.v=mem_e.v=0, fwd_sel=0, sp_sel=0, counters=0. hazard_stall then evaluates to 0.
  2. pipe_hold: every register holds. hazard_stall still reflects the inputs.
  3. flush: mem_e<=ex_e; ex_e.v<=0; fwd_sel<=0; sp_sel<=0. This overrides a simultaneous hazard.
  4. hazard_stall: mem_e<=ex_e; ex_e.v<=0 (bubble); fwd_sel<=0; sp_sel<=0. ID inputs are held by upstream.
  5. otherwise: mem_e<=ex_e; ex_e<={id_valid,id_dst,id_wb,id_load,id_sp_wr}; fwd_sel/sp_sel <= computed values, forced to 0 if !id_valid.
- Latency: the selects are valid in EX exactly one advancing cycle after the instruction leaves Decode.
- A load-use hazard stalls exactly one cycle. After the bubble the load sits in mem_e and the consumer gets 10.
- A bubble or invalid entry never matches, including dst==0.
- Two operands naming the same register get identical selects.

Optional Feature:
FWD_STATS_EN
- Defined:
  - stall_cnt increments on every cycle with hazard_stall & !pipe_hold & !rst.
  - fwd_cnt increments on every case-5 advance where any computed select is nonzero.
  - Both counters saturate at all-ones and clear on rst.
- Undefined: no counter flops; stall_cnt and fwd_cnt are tied to 0. Ports remain present.

Test Plan:
1. ADD r1 then ADD r2,r1 back-to-back -> consumer in EX with fwd_sel[1:0]=01, hazard_stall never 1.
2. ADD r1, NOP, SUB r3,r1 -> SUB in EX with fwd_sel[1:0]=10. Then ADD r1 and ADD r4 both writing r1, followed by a reader -> 01 (nearest producer wins).
3. LDD r5 followed by OR r5 -> hazard_stall=1 for exactly one cycle, EX gets a bubble (fwd_sel=0), OR in EX with fwd_sel[1:0]=10. With FWD_STATS_EN, stall_cnt=1.
4. Load-use with pipe_hold=1 for 3 cycles -> hazard_stall stays 1, shadow entries and selects unchanged. On release the single bubble is inserted, result as in scenario 3.
5. PUSH (sp_wr) followed by POP (sp_rd) -> sp_sel=01. With one intervening NOP -> sp_sel=10.
6. Load-use hazard coinciding with flush=1 -> hazard_stall=0, ex_e invalid, selects 0 the next cycle. Then rst mid-stream -> all outputs 0 on the following edge, and the next dependent instruction gets 00.
